// File: rtl/serdes_pkg.sv
// Shared SERDES definitions: K28.5 comma symbols, symbol width and the
// comma aligner lock-state encoding.
package serdes_pkg;

  localparam int unsigned SYM_W = 10;

  localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

  // Width of a counter that must reach max(a, b) without wrapping.
  function automatic int unsigned cnt_w(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/serdes_comma_detect.sv
// Combinational K28.5 comma compare on a registered symbol window.
// Shared between the aligner and the 8b/10b decoder.
module serdes_comma_detect
  import serdes_pkg::*;
#(
  parameter int unsigned      WIDTH   = SYM_W,
  parameter logic [WIDTH-1:0] COMMA_P = K28_5_RDN,
  parameter logic [WIDTH-1:0] COMMA_N = K28_5_RDP
) (
  input  logic [WIDTH-1:0] i_sr,
  output logic             o_hit,
  output logic             o_is_p,
  output logic             o_is_n
);

  logic w_is_p;
  logic w_is_n;

  always_comb begin
    w_is_p = (i_sr == COMMA_P);
    w_is_n = (i_sr == COMMA_N);
  end

  assign o_is_p = w_is_p;
  assign o_is_n = w_is_n;
  assign o_hit  = w_is_p | w_is_n;

endmodule

// File: rtl/sipo_comma_aligner.sv
// Serial-to-parallel deserializer with K28.5 comma alignment and a
// HUNT/VERIFY/LOCKED lock state machine feeding the 8b/10b decoder.
module sipo_comma_aligner
  import serdes_pkg::*;
#(
  parameter int unsigned      WIDTH      = SYM_W,
  parameter logic [WIDTH-1:0] COMMA_P    = K28_5_RDN,
  parameter logic [WIDTH-1:0] COMMA_N    = K28_5_RDP,
  parameter int unsigned      LOCK_CNT   = 3,
  parameter int unsigned      UNLOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             align_en,
  output logic [WIDTH-1:0] parallel_out,
  output logic             data_valid,
  output logic             comma_det,
  output logic             locked
);

  localparam int unsigned PH_W  = $clog2(WIDTH);
  localparam int unsigned CNT_W = cnt_w(LOCK_CNT, UNLOCK_CNT);

  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(WIDTH - 1);
  localparam logic [PH_W-1:0]  PH_REALIGN = PH_W'(1);
  localparam logic [CNT_W-1:0] LOCK_TGT   = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] UNLOCK_TGT = CNT_W'(UNLOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  align_state_e     r_state;
  logic [WIDTH-1:0] r_sr;
  logic [PH_W-1:0]  r_phase;
  logic [CNT_W-1:0] r_good;
  logic [CNT_W-1:0] r_bad;
  logic [WIDTH-1:0] r_parallel_out;
  logic             r_data_valid;
  logic             r_comma_det;
  logic             r_locked;

  logic             w_hit;
  logic             w_is_p;
  logic             w_is_n;
  logic             w_boundary;
  logic [CNT_W-1:0] w_good_inc;
  logic [CNT_W-1:0] w_bad_inc;

  serdes_comma_detect #(
    .WIDTH   (WIDTH),
    .COMMA_P (COMMA_P),
    .COMMA_N (COMMA_N)
  ) u_comma_detect (
    .i_sr   (r_sr),
    .o_hit  (w_hit),
    .o_is_p (w_is_p),
    .o_is_n (w_is_n)
  );

  always_comb begin
    w_boundary = (r_phase == '0) && (r_state != HUNT);
    w_good_inc = r_good + 1'b1;
    w_bad_inc  = r_bad + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr <= '0;
    end else begin
      r_sr <= {r_sr[WIDTH-2:0], serial_in};
    end
  end

  // Phase free-runs; the FSM overrides it only when (re)acquiring a comma so
  // that the next boundary lands exactly WIDTH cycles after the hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= HUNT;
      r_phase        <= '0;
      r_good         <= '0;
      r_bad          <= '0;
      r_parallel_out <= '0;
      r_data_valid   <= 1'b0;
      r_comma_det    <= 1'b0;
      r_locked       <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_comma_det  <= 1'b0;
      r_phase      <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;

      case (r_state)
        HUNT: begin
          if (align_en && w_hit) begin
            r_phase <= PH_REALIGN;
            r_good  <= CNT_ONE;
            r_state <= VERIFY;
          end
        end

        VERIFY: begin
          if (align_en && w_hit) begin
            if (w_boundary) begin
              r_good <= w_good_inc;
              if (w_good_inc == LOCK_TGT) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
                r_bad    <= '0;
              end
            end else begin
              r_phase <= PH_REALIGN;
              r_good  <= CNT_ONE;
            end
          end
        end

        LOCKED: begin
          if (w_boundary) begin
            r_parallel_out <= r_sr;
            r_data_valid   <= 1'b1;
            r_comma_det    <= w_is_p | w_is_n;
          end
          if (align_en && w_hit) begin
            if (w_boundary) begin
              r_bad <= '0;
            end else if (w_bad_inc == UNLOCK_TGT) begin
              r_state  <= HUNT;
              r_locked <= 1'b0;
              r_good   <= '0;
              r_bad    <= '0;
            end else begin
              r_bad <= w_bad_inc;
            end
          end
        end

        default: begin
          r_state  <= HUNT;
          r_locked <= 1'b0;
          r_good   <= '0;
          r_bad    <= '0;
        end
      endcase
    end
  end

  assign parallel_out = r_parallel_out;
  assign data_valid   = r_data_valid;
  assign comma_det    = r_comma_det;
  assign locked       = r_locked;

endmodule

// File: tb/tb_sipo_comma_aligner.sv
// Directed bench for sipo_comma_aligner: acquisition, lock, slip recovery,
// align_en freeze and asynchronous reset, with hand-derived expectations.
module tb_sipo_comma_aligner;

  localparam logic [9:0] CP  = 10'b0011111010;  // 0x0FA
  localparam logic [9:0] CN  = 10'b1100000101;  // 0x305
  localparam logic [9:0] D1  = 10'h2AA;
  localparam logic [9:0] D2  = 10'h155;
  localparam logic [9:0] OF1 = 10'h007;         // 00000_00111 : off-phase comma, first half
  localparam logic [9:0] OF2 = 10'h340;         // 11010_00000 : off-phase comma, second half

  logic       clk;
  logic       reset;
  logic       serial_in;
  logic       align_en;
  logic [9:0] parallel_out;
  logic       data_valid;
  logic       comma_det;
  logic       locked;

  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned cyc;

  logic [9:0]  vq[$];
  logic        cq[$];
  int unsigned tq[$];

  sipo_comma_aligner #(
    .WIDTH      (10),
    .COMMA_P    (10'b0011111010),
    .COMMA_N    (10'b1100000101),
    .LOCK_CNT   (3),
    .UNLOCK_CNT (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .align_en     (align_en),
    .parallel_out (parallel_out),
    .data_valid   (data_valid),
    .comma_det    (comma_det),
    .locked       (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
    cyc++;
    if (data_valid === 1'b1) begin
      vq.push_back(parallel_out);
      cq.push_back(comma_det);
      tq.push_back(cyc);
    end
  endtask

  task automatic send_from(input logic [9:0] s, input int start);
    for (int i = start; i >= 0; i--) send_bit(s[i]);
  endtask

  task automatic send_sym(input logic [9:0] s);
    send_from(s, 9);
  endtask

  task automatic clear_q;
    vq.delete();
    cq.delete();
    tq.delete();
  endtask

  task automatic do_reset(input logic en);
    reset     = 1'b1;
    serial_in = 1'b0;
    align_en  = en;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_q();
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    serial_in = 1'b0;
    align_en  = 1'b0;
    #3;
    n_checks++;
    if ({parallel_out, data_valid, comma_det, locked} !== 13'h0)
      $display("FAIL reset_outputs: got %h expected 0", {parallel_out, data_valid, comma_det, locked});
    else n_pass++;
    do_reset(1'b1);
    send_sym(CP);
    n_checks++;
    if (locked !== 1'b0 || data_valid !== 1'b0)
      $display("FAIL reset_hunt: locked=%b valid=%b expected 0/0", locked, data_valid);
    else n_pass++;
  endtask

  task automatic test_reset_midlock;
    do_reset(1'b1);
    send_sym(CP); send_sym(CN); send_sym(CP);
    send_sym(CN);
    send_bit(CP[9]);
    n_checks++;
    if (locked !== 1'b1 || data_valid !== 1'b1 || parallel_out !== CN)
      $display("FAIL midlock_pre: locked=%b valid=%b out=%h expected 1/1/305", locked, data_valid, parallel_out);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({parallel_out, data_valid, comma_det, locked} !== 13'h0)
      $display("FAIL midlock_async: got %h expected 0", {parallel_out, data_valid, comma_det, locked});
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_q();
    send_sym(CN); send_sym(CP);
    n_checks++;
    if (locked !== 1'b0) $display("FAIL midlock_reacq_early: locked=%b expected 0", locked);
    else n_pass++;
    send_sym(CN);
    send_bit(CP[9]);
    n_checks++;
    if (locked !== 1'b1 || vq.size() != 0)
      $display("FAIL midlock_relock: locked=%b nvalid=%0d expected 1/0", locked, vq.size());
    else n_pass++;
  endtask

  task automatic test_lock_offset;
    logic [9:0] exp_v[8];
    logic       exp_c[8];
    exp_v = '{D1, D2, CP, D1, D2, CP, D1, D2};
    exp_c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset(1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    send_sym(CP); send_sym(D1); send_sym(D2);
    send_sym(CP); send_sym(D1); send_sym(D2);
    send_sym(CP);
    n_checks++;
    if (locked !== 1'b0 || vq.size() != 0)
      $display("FAIL offset_prelock: locked=%b nvalid=%0d expected 0/0", locked, vq.size());
    else n_pass++;
    send_bit(D1[9]);
    n_checks++;
    if (locked !== 1'b1) $display("FAIL offset_lock_edge: locked=%b expected 1", locked);
    else n_pass++;
    send_from(D1, 8);
    send_sym(D2);
    send_sym(CP); send_sym(D1); send_sym(D2);
    send_sym(CP); send_sym(D1); send_sym(D2);
    send_bit(1'b0);
    n_checks++;
    if (vq.size() != 8) $display("FAIL offset_count: got %0d expected 8", vq.size());
    else n_pass++;
    for (int i = 0; i < 8 && i < vq.size(); i++) begin
      n_checks++;
      if (vq[i] !== exp_v[i] || cq[i] !== exp_c[i])
        $display("FAIL offset_sym%0d: got %h/%b expected %h/%b", i, vq[i], cq[i], exp_v[i], exp_c[i]);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (tq[i] - tq[i-1] != 10)
          $display("FAIL offset_spacing%0d: got %0d expected 10", i, tq[i] - tq[i-1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_alt_commas;
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    send_sym(CP); send_sym(CN);
    n_checks++;
    if (locked !== 1'b0) $display("FAIL alt_early: locked=%b expected 0", locked);
    else n_pass++;
    send_sym(CP);
    send_bit(CN[9]);
    n_checks++;
    if (locked !== 1'b1) $display("FAIL alt_lock: locked=%b expected 1", locked);
    else n_pass++;
    send_from(CN, 8);
    send_sym(CP); send_sym(CN); send_sym(CP);
    send_bit(1'b0);
    n_checks++;
    if (vq.size() != 4) $display("FAIL alt_count: got %0d expected 4", vq.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < vq.size(); i++) begin
      n_checks++;
      if (vq[i] !== ((i % 2 == 0) ? 10'h305 : 10'h0FA) || cq[i] !== 1'b1)
        $display("FAIL alt_sym%0d: got %h/%b expected %h/1", i, vq[i], cq[i],
                 (i % 2 == 0) ? 10'h305 : 10'h0FA);
      else n_pass++;
    end
  endtask

  task automatic test_slip;
    do_reset(1'b1);
    send_sym(CP); send_sym(CN); send_sym(CP);
    send_sym(CN); send_sym(CP);
    send_bit(1'b0);
    clear_q();
    send_sym(CN); send_sym(CP); send_sym(CN);
    send_sym(CP);
    n_checks++;
    if (locked !== 1'b1) $display("FAIL slip_still_locked: locked=%b expected 1", locked);
    else n_pass++;
    send_bit(CN[9]);
    n_checks++;
    if (locked !== 1'b0) $display("FAIL slip_unlock: locked=%b expected 0", locked);
    else n_pass++;
    n_checks++;
    if (vq.size() != 4) $display("FAIL slip_count: got %0d expected 4", vq.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < vq.size(); i++) begin
      n_checks++;
      if (vq[i] !== ((i % 2 == 0) ? 10'h182 : 10'h27D) || cq[i] !== 1'b0)
        $display("FAIL slip_sym%0d: got %h/%b expected %h/0", i, vq[i], cq[i],
                 (i % 2 == 0) ? 10'h182 : 10'h27D);
      else n_pass++;
    end
    clear_q();
    send_from(CN, 8);
    send_sym(CP); send_sym(CN);
    n_checks++;
    if (locked !== 1'b0 || vq.size() != 0)
      $display("FAIL slip_no_valid: locked=%b nvalid=%0d expected 0/0", locked, vq.size());
    else n_pass++;
    send_bit(CP[9]);
    n_checks++;
    if (locked !== 1'b1) $display("FAIL slip_relock: locked=%b expected 1", locked);
    else n_pass++;
    send_from(CP, 8);
    send_sym(CN);
    send_bit(1'b0);
    n_checks++;
    if (vq.size() != 2 || vq[0] !== CP || vq[1] !== CN)
      $display("FAIL slip_realigned: n=%0d first=%h expected 2/0fa", vq.size(), vq.size() > 0 ? vq[0] : 10'h0);
    else n_pass++;
  endtask

  task automatic test_single_offphase;
    logic [9:0] exp_v[11];
    logic       exp_c[11];
    exp_v = '{CN, OF1, OF2, CP, OF1, OF2, OF1, OF2, OF1, OF2, CP};
    exp_c = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset(1'b1);
    send_sym(CP); send_sym(CN); send_sym(CP);
    send_sym(CN);
    send_sym(OF1); send_sym(OF2);
    n_checks++;
    if (locked !== 1'b1) $display("FAIL single_after_off: locked=%b expected 1", locked);
    else n_pass++;
    send_sym(CP);
    for (int k = 0; k < 3; k++) begin
      send_sym(OF1); send_sym(OF2);
    end
    n_checks++;
    if (locked !== 1'b1) $display("FAIL single_bad_cleared: locked=%b expected 1", locked);
    else n_pass++;
    send_sym(CP);
    send_bit(1'b0);
    n_checks++;
    if (vq.size() != 11) $display("FAIL single_count: got %0d expected 11", vq.size());
    else n_pass++;
    for (int i = 0; i < 11 && i < vq.size(); i++) begin
      n_checks++;
      if (vq[i] !== exp_v[i] || cq[i] !== exp_c[i])
        $display("FAIL single_sym%0d: got %h/%b expected %h/%b", i, vq[i], cq[i], exp_v[i], exp_c[i]);
      else n_pass++;
    end
  endtask

  task automatic test_align_en;
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) begin
      send_sym(CP); send_sym(CN);
    end
    send_sym(D1);
    n_checks++;
    if (locked !== 1'b0 || vq.size() != 0)
      $display("FAIL en_frozen: locked=%b nvalid=%0d expected 0/0", locked, vq.size());
    else n_pass++;
    align_en = 1'b1;
    send_sym(CP); send_sym(CN); send_sym(CP);
    n_checks++;
    if (locked !== 1'b0) $display("FAIL en_early: locked=%b expected 0", locked);
    else n_pass++;
    send_bit(CN[9]);
    n_checks++;
    if (locked !== 1'b1) $display("FAIL en_lock: locked=%b expected 1", locked);
    else n_pass++;
    send_from(CN, 8);
    send_sym(CP);
    send_bit(1'b0);
    n_checks++;
    if (vq.size() != 2 || vq[0] !== CN || vq[1] !== CP)
      $display("FAIL en_outputs: n=%0d first=%h expected 2/305", vq.size(), vq.size() > 0 ? vq[0] : 10'h0);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    test_reset();
    test_reset_midlock();
    test_lock_offset();
    test_alt_commas();
    test_slip();
    test_single_offphase();
    test_align_en();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
